// File: rtl/alu_arb_pkg.sv
// Shared FSM state type and ALU opcode constants for the round-robin ALU arbiter.
package alu_arb_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Opcodes are forwarded to the ALU untouched; these names are for users of the block.
    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Requester-side and ALU-side signal bundle of the arbiter; slave = arbiter, master = environment.
interface alu_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic [NUM_REQ*OP_W-1:0]    req_op;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [WIDTH-1:0]           resp_result;
    logic                       resp_err;
    logic                       busy;
    logic                       alu_valid;
    logic [WIDTH-1:0]           alu_a;
    logic [WIDTH-1:0]           alu_b;
    logic [OP_W-1:0]            alu_op;
    logic [WIDTH-1:0]           alu_result;
    logic                       alu_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_ready,
        output req_ready, resp_valid, resp_result, resp_err, busy,
               alu_valid, alu_a, alu_b, alu_op
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_ready,
        input  req_ready, resp_valid, resp_result, resp_err, busy,
               alu_valid, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_REQ);

    always_comb begin
        logic [IDX_W:0] cand;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr < NUM_REQ, so one conditional subtract implements the wrap.
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= LIMIT) begin
                cand = cand - LIMIT;
            end
            if (!any_req && req[cand[IDX_W-1:0]]) begin
                any_req                 = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, one operation in flight.
// Optional WAIT-state watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    alu_rr_arbiter_if.slave  bus
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("alu_rr_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [OP_W-1:0]      op_q;
    logic [WIDTH-1:0]     result_q;
    logic                 expired;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   resp_valid;
    logic                 alu_valid;
    logic                 busy;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Cleared in ISSUE so the count starts at zero on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A result arriving in the expiry cycle takes precedence over the timeout.
    assign expired = (state == WAIT) && !bus.alu_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == WAIT) begin
            if (bus.alu_ready) begin
                err_q <= 1'b0;
            end else if (expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.resp_err = err_q;
`else
    assign expired      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        alu_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req_ready = pick_grant;
                end
                if (pick_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                alu_valid  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.alu_ready || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[gnt_idx] = 1'b1;
                state_next          = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture on accept, latch the ALU answer in WAIT, advance the pointer only after responding.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            gnt_idx  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_idx;
                        a_q     <= bus.req_a[pick_idx*WIDTH +: WIDTH];
                        b_q     <= bus.req_b[pick_idx*WIDTH +: WIDTH];
                        op_q    <= bus.req_op[pick_idx*OP_W +: OP_W];
                    end
                end
                WAIT: begin
                    if (bus.alu_ready) begin
                        result_q <= bus.alu_result;
                    end else if (expired) begin
                        result_q <= '0;
                    end
                end
                RESP: begin
                    ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_result = result_q;
    assign bus.busy        = busy;
    assign bus.alu_valid   = alu_valid;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized bench for alu_rr_arbiter with an operation-level reference model and a behavioural ALU.
module tb_alu_rr_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic model_rdy;
    logic stray_rdy;

    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    assign bus.alu_ready = model_rdy | stray_rdy;

    alu_rr_arbiter #(
        .NUM_REQ        (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OP_W-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[2:0];
            OP_SHR:  return a >> b[2:0];
            default: return a;
        endcase
    endfunction

    // Requester-side operand storage
    logic [W-1:0]    ra  [N];
    logic [W-1:0]    rb  [N];
    logic [OP_W-1:0] rop [N];

    task automatic new_operands(input int i);
        ra[i]  = W'($urandom);
        rb[i]  = W'($urandom);
        rop[i] = OP_W'($urandom);
    endtask

    task automatic drive(input logic [N-1:0] pat);
        bus.req_valid = pat;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W]        = ra[i];
            bus.req_b[i*W +: W]        = rb[i];
            bus.req_op[i*OP_W +: OP_W] = rop[i];
        end
    endtask

    // Behavioural ALU: answers alu_lat cycles after alu_valid; alu_lat == 0 means never.
    int              alu_lat = 1;
    int              pending = 0;
    logic [W-1:0]    lat_a;
    logic [W-1:0]    lat_b;
    logic [OP_W-1:0] lat_op;

    initial begin
        model_rdy      = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            model_rdy      = 1'b0;
            bus.alu_result = W'($urandom);
            if (rst) begin
                pending = 0;
            end else if (bus.alu_valid) begin
                pending = alu_lat;
                lat_a   = bus.alu_a;
                lat_b   = bus.alu_b;
                lat_op  = bus.alu_op;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    model_rdy      = 1'b1;
                    bus.alu_result = alu_fn(lat_a, lat_b, lat_op);
                end
            end
        end
    end

    // Reference arbiter: next requester in circular order starting at the pointer.
    int ptr_m = 0;

    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (((v >> c) & N'(1)) != '0) return c;
        end
        return -1;
    endfunction

    // One full operation starting in an IDLE cycle; returns the index the DUT granted.
    task automatic run_op(input logic [N-1:0] pat, input int lat, output int obs);
        int           g;
        int           n;
        int           exp_n;
        logic [W-1:0] exp_res;
        logic         exp_err;
        @(negedge clk);
        alu_lat = lat;
        drive(pat);
        #1;
        g   = model_pick(pat, ptr_m);
        obs = -1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs = i;
        check("idle_busy", 32'(bus.busy), 0);
        check("req_ready", 32'(bus.req_ready), 32'(1) << g);
        if (lat == 0 || lat > TO) begin
            exp_n   = TO + 1;
            exp_res = '0;
            exp_err = 1'b1;
        end else begin
            exp_n   = lat + 1;
            exp_res = alu_fn(ra[g], rb[g], rop[g]);
            exp_err = 1'b0;
        end
        @(negedge clk);
        #1;
        check("alu_valid", 32'(bus.alu_valid), 1);
        check("alu_a", 32'(bus.alu_a), 32'(ra[g]));
        check("alu_b", 32'(bus.alu_b), 32'(rb[g]));
        check("alu_op", 32'(bus.alu_op), 32'(rop[g]));
        check("issue_no_ready", 32'(bus.req_ready), 0);
        n = 0;
        while (bus.resp_valid == '0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("resp_latency", n, exp_n);
        check("resp_valid", 32'(bus.resp_valid), 32'(1) << g);
        check("resp_result", 32'(bus.resp_result), 32'(exp_res));
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        ptr_m = (g + 1) % N;
        new_operands(g);
    endtask

    // Protocol invariants sampled mid-cycle every clock.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b0) begin
                check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
                check("resp_onehot", 32'($countones(bus.resp_valid) <= 1), 1);
                check("ready_only_idle", 32'(bus.busy && (bus.req_ready != '0)), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs;
        stray_rdy = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < N; i++) new_operands(i);
        drive('1);

        // Reset with every requester asserting
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_req_ready", 32'(bus.req_ready), 0);
            check("rst_resp_valid", 32'(bus.resp_valid), 0);
            check("rst_resp_result", 32'(bus.resp_result), 0);
            check("rst_resp_err", 32'(bus.resp_err), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_alu_valid", 32'(bus.alu_valid), 0);
            check("rst_alu_a", 32'(bus.alu_a), 0);
            check("rst_alu_b", 32'(bus.alu_b), 0);
            check("rst_alu_op", 32'(bus.alu_op), 0);
        end
        drive('0);
        rst   = 1'b0;
        ptr_m = 0;

        // Fairness: all requesters held valid
        for (int k = 0; k < 8; k++) begin
            run_op('1, 1, obs);
            check("fair_order", obs, k % N);
        end

        // Single request, two-cycle ALU
        ra[0]  = 8'h05;
        rb[0]  = 8'h03;
        rop[0] = 3'd0;
        run_op(4'b0001, 2, obs);
        check("single_grant", obs, 0);
        check("single_result", 32'(bus.resp_result), 32'h08);

        // Pointer wrap past the top requester
        run_op(4'b0100, 1, obs);
        check("wrap_serve2", obs, 2);
        run_op(4'b1001, 1, obs);
        check("wrap_first", obs, 3);
        run_op(4'b1001, 1, obs);
        check("wrap_second", obs, 0);

        // Reset while waiting on a silent ALU, then a stray alu_ready
        @(negedge clk);
        alu_lat = 0;
        drive(4'b0010);
        #1;
        check("rw_grant", 32'(bus.req_ready), 32'(1) << model_pick(4'b0010, ptr_m));
        repeat (3) @(negedge clk);
        #1;
        check("rw_busy_wait", 32'(bus.busy), 1);
        rst = 1'b1;
        drive('0);
        @(negedge clk);
        #1;
        check("rw_busy_rst", 32'(bus.busy), 0);
        check("rw_resp_rst", 32'(bus.resp_valid), 0);
        check("rw_alu_a_rst", 32'(bus.alu_a), 0);
        rst   = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        stray_rdy = 1'b1;
        #1;
        check("rw_stray_busy", 32'(bus.busy), 0);
        @(negedge clk);
        stray_rdy = 1'b0;
        #1;
        check("rw_stray_resp", 32'(bus.resp_valid), 0);
        check("rw_stray_busy2", 32'(bus.busy), 0);
        run_op('1, 1, obs);
        check("rw_post_grant", obs, 0);

        // Randomized traffic with occasional idle cycles
        for (int k = 0; k < 40; k++) begin
            run_op(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, 5), obs);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                drive('0);
                #1;
                check("idle_no_ready", 32'(bus.req_ready), 0);
                @(negedge clk);
                #1;
                check("idle_stays", 32'(bus.busy), 0);
            end
        end

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers, then answers exactly on the expiry cycle
        run_op(4'b0100, 0, obs);
        run_op(4'b0100, TO, obs);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one ALU datapath between NUM_REQ independent requesters using round-robin arbitration. The block sits between requester ports and the ALU's valid/a/b/op and result/ready signals. It keeps at most one ALU operation outstanding at a time. It captures the winning request, issues it to the ALU, waits for the ALU's ready, and returns the result to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 8, operand/result width; matches ALU WIDTH
TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with ALU_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request
req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand B, same packing
req_op  in  NUM_REQ*3  opcode, requester i at [i*3 +: 3]
req_ready  out  NUM_REQ  one-hot accept; request captured on this edge
resp_valid  out  NUM_REQ  one-hot one-cycle result strobe
resp_result  out  WIDTH  result, valid when any resp_valid bit is high
resp_err  out  1  timeout flag, qualified by resp_valid
busy  out  1  high in any state other than IDLE
alu_valid  out  1  one-cycle issue strobe to ALU
alu_a  out  WIDTH  captured operand A
alu_b  out  WIDTH  captured operand B
alu_op  out  3  captured opcode
alu_result  in  WIDTH  ALU result
alu_ready  in  1  ALU result strobe

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ptr=0, grant index=0.
  - All outputs 0: req_ready, resp_valid, resp_result, resp_err, busy, alu_valid, alu_a, alu_b, alu_op.
  - Reset mid-operation abandons the operation. No resp_valid is produced. A later stray alu_ready is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready[g] is combinational in this cycle. On the edge: register a/b/op of g and the index g, then go to ISSUE.
  - If no req_valid bit is set, stay in IDLE and hold req_ready=0.
- ISSUE:
  - alu_valid=1 for exactly one cycle with the captured a/b/op, then go to WAIT.
  - alu_a, alu_b and alu_op hold their value until the next capture.
- WAIT:
  - On alu_ready=1, register alu_result and go to RESP.
  - The ALU's minimum latency is 1 cycle after alu_valid.
  - alu_ready is sampled only in WAIT. In all other states it is ignored.
- RESP:
  - resp_valid[g]=1 for one cycle and resp_result=captured result. There is no backpressure.
  - ptr <= (g+1) mod NUM_REQ, then go to IDLE.
- Requester-visible timing:
  - Accept edge T, alu_valid in T+1, RESP in the cycle after alu_ready.
  - Minimum period is 4 cycles per operation for a 1-cycle ALU.
- Requester obligations:
  - Hold req_valid and operands stable until req_ready.
  - Dropping req_valid before the grant is legal; the bit simply does not participate.
- req_ready is never asserted outside IDLE. At most one req_ready bit and one resp_valid bit are high in any cycle.
- Opcodes are passed through unchecked. Result width equals WIDTH; no truncation or extension.
- ptr advances only on RESP. Arbitration is therefore fair: any continuously asserted requester is served within NUM_REQ operations.

Optional Feature:
ALU_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without alu_ready, go to RESP with resp_result=0 and resp_err=1.
  - alu_ready in the same cycle as expiry wins: normal result, resp_err=0.
- Undefined: no counter; WAIT waits indefinitely; resp_err is tied to 0.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP), 2 bits;
  - ALU opcode constants, 3-bit localparams;
  - OP_W=3.
- One sub-module, rr_pick: purely combinational. It takes req vector and ptr, and outputs a one-hot grant and its index plus an any flag.

Test Plan:
- Reset: rst=1 for 3 cycles with all req_valid=1 -> every output 0; after release, first grant goes to requester 0.
- Single request: req 0 with a=8'h05, b=8'h03, op=3'd0; ALU model latency 2 returning 8'h08 -> req_ready=4'b0001 at T, alu_valid at T+1, resp_valid=4'b0001 with resp_result=8'h08 one cycle after alu_ready.
- Fairness: all 4 requesters held valid for 8 operations -> grant order 0,1,2,3,0,1,2,3; never two req_ready bits high at once.
- Pointer wrap: after requester 2 is served, only req 0 and 3 are valid -> grant 3 first, then 0.
- Reset in WAIT: assert rst during WAIT, then pulse alu_ready after release -> no resp_valid, busy=0, next grant searches from 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): ALU never ready -> resp_valid exactly 16 WAIT cycles after entry, with resp_err=1 and resp_result=0. A separate run with alu_ready on cycle 16 -> resp_err=0 and the real result.
